mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter between the pipelined datapath and the single physical memory/cache port. It accepts the datapath's instruction-fetch and data-access request ports, grants one at a time and latches its fields, drives one physical memory transaction, and routes the response back to the requester that was granted. Data requests have priority, because they come from the older instruction. An optional starvation guard bounds how long fetch can wait.

## Interface
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch is pending (starvation guard only), range 1–15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- instr_mem_read  in  1  fetch request, held until instr_mem_resp.
- instr_mem_address  in  32  fetch address.
- instr_mem_rdata  out  32  fetch data, valid while instr_mem_resp=1.
- instr_mem_resp  out  1  one-cycle fetch completion.
- data_mem_read  in  1  load request, held until data_mem_resp.
- data_mem_write  in  1  store request, held until data_mem_resp.
- data_mem_address  in  32  load/store address.
- data_mem_wdata  in  32  store data.
- mem_byte_enable  in  4  store byte lanes.
- data_mem_rdata  out  32  load data, valid while data_mem_resp=1.
- data_mem_resp  out  1  one-cycle data completion.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_address  out  32  latched address.
- pmem_wdata  out  32  latched store data.
- pmem_byte_enable  out  4  latched byte lanes; 4'b1111 for reads.
- pmem_rdata  in  32  physical read data.
- pmem_resp  in  1  physical completion, one cycle.

## Operation
- **States:** IDLE, SERVE_D, SERVE_I.
- **IDLE:**
  - data_req = data_mem_read|data_mem_write.
  - If data_req and not fetch-priority → SERVE_D.
  - Else if instr_mem_read → SERVE_I.
  - Else stay in IDLE.
- **Latching at grant:** on the IDLE→SERVE edge, capture address, wdata, byte enable and the read/write kind into registers. pmem_* are driven only from these registers, so requester changes mid-transaction have no effect.
- **Read and write together:** data_mem_read and data_mem_write both high is treated as a write.
- **SERVE_D:**
  - pmem_write = latched write; pmem_read = ~latched write.
  - On pmem_resp: data_mem_resp=1, data_mem_rdata=pmem_rdata (combinational pass-through), next state IDLE.
- **SERVE_I:**
  - pmem_read=1.
  - On pmem_resp: instr_mem_resp=1, instr_mem_rdata=pmem_rdata, next state IDLE.
- **Response routing:**
  - A response is never routed to the non-granted side.
  - pmem_resp in IDLE is ignored.
  - The rdata output of the side not responding is 0.
- **Fetch-priority:** always 0 unless the guard is compiled in (see Configuration).
- **Reset:**
  - State returns to IDLE and all pmem_* outputs, responses and rdata go to 0.
  - A transaction in flight is abandoned; a late pmem_resp after reset is ignored.
  - The streak counter clears to 0.

## Timing
- A request seen in IDLE at cycle N gives registered pmem strobes at N+1.
- A pmem_resp at cycle M gives the requester's resp at M, combinationally.
- The FSM is in IDLE at M+1; the next grant's strobes appear at M+2.
- Minimum request→resp latency is 1 + memory latency.
- A request is accepted only in IDLE. Back-to-back transactions are separated by exactly one IDLE cycle.
- Strobes stay asserted every cycle of SERVE_* until the pmem_resp cycle inclusive, then deassert at M+1.

## Configuration
- **ARB_STARVE_GUARD_EN defined:**
  - 4-bit streak counter increments on each data grant made while instr_mem_read=1.
  - It clears on any fetch grant, and on a data grant made with no fetch pending.
  - When streak ≥ MAX_D_STREAK, fetch-priority=1 and the next IDLE decision grants SERVE_I even if data_req is set.
- **Not defined:** strict data priority. No counter is built, and fetch can starve indefinitely under continuous data requests.

## Test plan
- **Reset values:** pulse rst low mid-SERVE_D, then assert pmem_resp. Every output is 0 throughout, and data_mem_resp stays 0.
- **Single fetch:** instr_mem_read=1, address 0x60, memory returns 0x00A00093 after 2 cycles. Expect pmem_read at N+1 with pmem_address 0x60, then instr_mem_resp for one cycle with rdata 0x00A00093, and data_mem_resp never set.
- **Simultaneous requests:**
  - Fetch at 0x64 plus load at 0x100 in the same cycle. The load is served first (pmem_address 0x100, pmem_byte_enable 4'b1111), then one IDLE cycle, then the fetch at 0x64.
- **Store latching:** store 0xDEADBEEF to 0x202 with byte enable 4'b0100, and change data_mem_wdata to 0 after the grant. Expect pmem_write=1, pmem_wdata 0xDEADBEEF, pmem_byte_enable 4'b0100 held until resp, and pmem_read=0.
- **Starvation guard:**
  - With ARB_STARVE_GUARD_EN and MAX_D_STREAK=4, hold data and fetch requests continuously. Expect exactly 4 data transactions, then 1 fetch, repeating.
  - Without the macro, zero fetch grants over 20 transactions.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the datapath fetch and data request ports onto one physical memory port.
// Define ARB_STARVE_GUARD_EN to build the fetch starvation guard (adds parameter MAX_D_STREAK).
module mem_arbiter
`ifdef ARB_STARVE_GUARD_EN
#(
   parameter int unsigned MAX_D_STREAK = 4
)
`endif
(
   input  logic        clk,
   input  logic        rst,

   input  logic        instr_mem_read,
   input  logic [31:0] instr_mem_address,
   output logic [31:0] instr_mem_rdata,
   output logic        instr_mem_resp,

   input  logic        data_mem_read,
   input  logic        data_mem_write,
   input  logic [31:0] data_mem_address,
   input  logic [31:0] data_mem_wdata,
   input  logic [3:0]  mem_byte_enable,
   output logic [31:0] data_mem_rdata,
   output logic        data_mem_resp,

   output logic        pmem_read,
   output logic        pmem_write,
   output logic [31:0] pmem_address,
   output logic [31:0] pmem_wdata,
   output logic [3:0]  pmem_byte_enable,
   input  logic [31:0] pmem_rdata,
   input  logic        pmem_resp
);

   typedef enum logic [1:0] {
      StIdle,
      StServeD,
      StServeI
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        write_q, write_d;
   logic        data_req;
   logic        fetch_prio;

   assign data_req = data_mem_read | data_mem_write;

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      be_d            = be_q;
      write_d         = write_q;
      data_mem_resp   = 1'b0;
      data_mem_rdata  = '0;
      instr_mem_resp  = 1'b0;
      instr_mem_rdata = '0;
      unique case (state_q)
         StIdle: begin
            if (data_req && !fetch_prio) begin
               state_d = StServeD;
               addr_d  = data_mem_address;
               // Read and write together is a write.
               write_d = data_mem_write;
               wdata_d = data_mem_write ? data_mem_wdata : '0;
               be_d    = data_mem_write ? mem_byte_enable : 4'b1111;
            end else if (instr_mem_read) begin
               state_d = StServeI;
               addr_d  = instr_mem_address;
               write_d = 1'b0;
               wdata_d = '0;
               be_d    = 4'b1111;
            end
         end
         StServeD: begin
            if (pmem_resp) begin
               data_mem_resp  = 1'b1;
               data_mem_rdata = pmem_rdata;
               state_d        = StIdle;
            end
         end
         StServeI: begin
            if (pmem_resp) begin
               instr_mem_resp  = 1'b1;
               instr_mem_rdata = pmem_rdata;
               state_d         = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         write_q <= write_d;
      end
   end

   // Strobes come only from registered state so requester changes cannot leak through.
   assign pmem_read        = (state_q == StServeI) || ((state_q == StServeD) && !write_q);
   assign pmem_write       = (state_q == StServeD) && write_q;
   assign pmem_address     = addr_q;
   assign pmem_wdata       = wdata_q;
   assign pmem_byte_enable = be_q;

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] streak_q, streak_d;
   logic       grant_d, grant_i;

   assign grant_d = (state_q == StIdle) && data_req && !fetch_prio;
   assign grant_i = (state_q == StIdle) && !grant_d && instr_mem_read;

   // Qualified by a pending fetch so a stale streak can never stall the data side.
   assign fetch_prio = (32'(streak_q) >= MAX_D_STREAK) && instr_mem_read;

   always_comb begin
      streak_d = streak_q;
      if (grant_d) begin
         if (!instr_mem_read) begin
            streak_d = '0;
         end else if (streak_q != 4'hf) begin
            streak_d = streak_q + 4'd1;
         end
      end else if (grant_i) begin
         streak_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end
`else
   assign fetch_prio = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected transactions are queued when requests are driven
// and checked against the physical port as each grant appears.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_mem_read;
   logic [31:0] instr_mem_address;
   logic [31:0] instr_mem_rdata;
   logic        instr_mem_resp;
   logic        data_mem_read;
   logic        data_mem_write;
   logic [31:0] data_mem_address;
   logic [31:0] data_mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic [31:0] data_mem_rdata;
   logic        data_mem_resp;
   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_address;
   logic [31:0] pmem_wdata;
   logic [3:0]  pmem_byte_enable;
   logic [31:0] pmem_rdata;
   logic        pmem_resp;

   mem_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .instr_mem_read    (instr_mem_read),
      .instr_mem_address (instr_mem_address),
      .instr_mem_rdata   (instr_mem_rdata),
      .instr_mem_resp    (instr_mem_resp),
      .data_mem_read     (data_mem_read),
      .data_mem_write    (data_mem_write),
      .data_mem_address  (data_mem_address),
      .data_mem_wdata    (data_mem_wdata),
      .mem_byte_enable   (mem_byte_enable),
      .data_mem_rdata    (data_mem_rdata),
      .data_mem_resp     (data_mem_resp),
      .pmem_read         (pmem_read),
      .pmem_write        (pmem_write),
      .pmem_address      (pmem_address),
      .pmem_wdata        (pmem_wdata),
      .pmem_byte_enable  (pmem_byte_enable),
      .pmem_rdata        (pmem_rdata),
      .pmem_resp         (pmem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          fetch;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   txn_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_fetch = 0;
   int   n_data  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pmem_read"}, pmem_read, 0);
      chk({tag, "_pmem_write"}, pmem_write, 0);
      chk({tag, "_pmem_address"}, pmem_address, 0);
      chk({tag, "_pmem_wdata"}, pmem_wdata, 0);
      chk({tag, "_pmem_be"}, pmem_byte_enable, 0);
      chk({tag, "_resps"}, {instr_mem_resp, data_mem_resp}, 0);
      chk({tag, "_instr_rdata"}, instr_mem_rdata, 0);
      chk({tag, "_data_rdata"}, data_mem_rdata, 0);
   endtask

   // Wait for a grant, check it against the scoreboard head, hold for lat cycles, respond.
   task automatic serve(input int lat, input logic [31:0] rdata, input bit drop,
                        input bit scramble);
      txn_t t;
      int   waited;
      bit   seen;
      seen = 0;
      for (waited = 0; waited < 20 && !seen; waited++) begin
         @(negedge clk);
         if (pmem_read || pmem_write) seen = 1;
      end
      if (!seen) begin
         chk("grant_timeout", 0, 1);
         return;
      end
      chk("grant_latency", waited, 1);
      if (exp_q.size() == 0) begin
         chk("unexpected_grant", 0, 1);
         return;
      end
      t = exp_q.pop_front();
      if (t.fetch) n_fetch++;
      else n_data++;
      if (scramble) begin
         data_mem_wdata   = '0;
         data_mem_address = '0;
         mem_byte_enable  = '0;
      end
      for (int k = 0; k < lat; k++) begin
         if (k > 0) @(negedge clk);
         chk("pmem_read", pmem_read, !t.wr);
         chk("pmem_write", pmem_write, t.wr);
         chk("pmem_address", pmem_address, t.addr);
         chk("pmem_be", pmem_byte_enable, t.be);
         if (t.wr) chk("pmem_wdata", pmem_wdata, t.wdata);
         chk("early_resp", {instr_mem_resp, data_mem_resp}, 0);
      end
      pmem_rdata = rdata;
      pmem_resp  = 1'b1;
      #1;
      chk("resp_cycle_strobe", pmem_read | pmem_write, 1);
      chk("instr_resp", instr_mem_resp, t.fetch);
      chk("data_resp", data_mem_resp, !t.fetch);
      chk("instr_rdata", instr_mem_rdata, t.fetch ? rdata : 32'h0);
      chk("data_rdata", data_mem_rdata, t.fetch ? 32'h0 : rdata);
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      if (drop) begin
         if (t.fetch) instr_mem_read = 1'b0;
         else begin
            data_mem_read  = 1'b0;
            data_mem_write = 1'b0;
         end
      end
      @(negedge clk);
      chk("idle_gap", pmem_read | pmem_write, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit guard;
`ifdef ARB_STARVE_GUARD_EN
      guard = 1;
`else
      guard = 0;
`endif
      rst               = 1'b0;
      instr_mem_read    = 1'b0;
      instr_mem_address = '0;
      data_mem_read     = 1'b0;
      data_mem_write    = 1'b0;
      data_mem_address  = '0;
      data_mem_wdata    = '0;
      mem_byte_enable   = '0;
      pmem_rdata        = '0;
      pmem_resp         = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;

      // Spurious memory response while idle is ignored.
      @(negedge clk);
      pmem_rdata = 32'h1234_5678;
      pmem_resp  = 1'b1;
      #1;
      chk_all_zero("idle_resp");
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      @(negedge clk);
      chk("idle_resp_no_grant", pmem_read | pmem_write, 0);

      // Single fetch.
      @(negedge clk);
      instr_mem_read    = 1'b1;
      instr_mem_address = 32'h60;
      exp_q.push_back('{1'b1, 1'b0, 32'h60, 32'h0, 4'b1111});
      serve(2, 32'h00A0_0093, 1, 0);

      // Simultaneous fetch and load: load first, then fetch after one idle cycle.
      @(negedge clk);
      instr_mem_read    = 1'b1;
      instr_mem_address = 32'h64;
      data_mem_read     = 1'b1;
      data_mem_address  = 32'h100;
      exp_q.push_back('{1'b0, 1'b0, 32'h100, 32'h0, 4'b1111});
      exp_q.push_back('{1'b1, 1'b0, 32'h64, 32'h0, 4'b1111});
      serve(1, 32'h1111_1111, 1, 0);
      serve(2, 32'h2222_2222, 1, 0);

      // Store with read also high; inputs scrambled after the grant.
      @(negedge clk);
      data_mem_read    = 1'b1;
      data_mem_write   = 1'b1;
      data_mem_address = 32'h202;
      data_mem_wdata   = 32'hDEAD_BEEF;
      mem_byte_enable  = 4'b0100;
      exp_q.push_back('{1'b0, 1'b1, 32'h202, 32'hDEAD_BEEF, 4'b0100});
      serve(3, 32'h0, 1, 1);

      // Continuous fetch and load requests.
      @(negedge clk);
      n_fetch           = 0;
      n_data            = 0;
      instr_mem_read    = 1'b1;
      instr_mem_address = 32'h400;
      data_mem_read     = 1'b1;
      data_mem_address  = 32'h300;
      for (int i = 0; i < 20; i++) begin
         if (guard && (i % 5 == 4)) exp_q.push_back('{1'b1, 1'b0, 32'h400, 32'h0, 4'b1111});
         else exp_q.push_back('{1'b0, 1'b0, 32'h300, 32'h0, 4'b1111});
      end
      for (int i = 0; i < 20; i++) begin
         serve(1, 32'hA000_0000 + 32'(i), 0, 0);
      end
      instr_mem_read = 1'b0;
      data_mem_read  = 1'b0;
      chk("starve_fetch_grants", n_fetch, guard ? 4 : 0);
      chk("starve_data_grants", n_data, guard ? 16 : 20);
      chk("queue_drained", exp_q.size(), 0);

      // Reset in the middle of a load, then a late memory response.
      @(negedge clk);
      data_mem_read    = 1'b1;
      data_mem_address = 32'h500;
      @(negedge clk);
      chk("pre_reset_grant", pmem_read, 1);
      rst           = 1'b0;
      data_mem_read = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      pmem_rdata = 32'hCAFE_F00D;
      pmem_resp  = 1'b1;
      #1;
      chk("reset_resp_ignored", data_mem_resp, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("late_resp_ignored", data_mem_resp, 0);
      chk("late_resp_rdata", data_mem_rdata, 0);
      chk("late_resp_strobes", pmem_read | pmem_write, 0);
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      @(negedge clk);
      chk_all_zero("post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
